// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: fetch and load/store share one memory port,
// one transaction in flight, data has priority with a starvation bound for fetch.
module mem_port_arbiter #(
    parameter int ADDRESS     = 32,
    parameter int INSTRUCTION = 32,
    parameter int MAX_STARVE  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDRESS-1:0]     if_addr,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [INSTRUCTION-1:0] if_rdata,
    input  logic                   dm_req,
    input  logic                   dm_we_re,
    input  logic [3:0]             dm_mask,
    input  logic [ADDRESS-1:0]     dm_addr,
    input  logic [INSTRUCTION-1:0] dm_wdata,
    output logic                   dm_gnt,
    output logic                   dm_rvalid,
    output logic [INSTRUCTION-1:0] dm_rdata,
    output logic                   mem_request,
    output logic                   mem_we_re,
    output logic [3:0]             mem_mask,
    output logic [ADDRESS-1:0]     mem_addr,
    output logic [INSTRUCTION-1:0] mem_wdata,
    input  logic                   mem_ready,
    input  logic                   mem_rvalid,
    input  logic [INSTRUCTION-1:0] mem_rdata
);
    localparam int CW = $clog2(MAX_STARVE + 1);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic idle, busy, starve_max, sel_if, sel_dm;

    always_comb begin
        // Outputs are gated by rst so nothing leaks out while reset is held.
        idle       = (state_q == IDLE) && !rst;
        busy       = (state_q == BUSY) && !rst;
        starve_max = (starve_cnt_q == CW'(MAX_STARVE));
        sel_if     = idle & if_req & (~dm_req | starve_max);
        sel_dm     = idle & dm_req & ~sel_if;

        mem_request = sel_if | sel_dm;
        mem_we_re   = 1'b0;
        mem_mask    = 4'b0000;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (sel_if) begin
            mem_mask = 4'b1111;
            mem_addr = if_addr;
        end else if (sel_dm) begin
            mem_we_re = dm_we_re;
            mem_mask  = dm_mask;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end

        if_gnt = sel_if & mem_ready;
        dm_gnt = sel_dm & mem_ready;

        if_rvalid = busy & mem_rvalid & (owner_q == OWN_IF);
        dm_rvalid = busy & mem_rvalid & (owner_q == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;

        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        if (if_gnt) begin
            state_d      = BUSY;
            owner_d      = OWN_IF;
            starve_cnt_d = '0;
        end else if (dm_gnt) begin
            state_d = BUSY;
            owner_d = OWN_DM;
            // Count only grants that actually bypassed a waiting fetch; saturate.
            if (if_req)
                starve_cnt_d = starve_max ? starve_cnt_q : starve_cnt_q + CW'(1);
            else
                starve_cnt_d = '0;
        end
        if (busy && mem_rvalid) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory request port between the instruction-fetch requester and the load/store (data) requester.
- Fetch requests are always full-word reads. Data requests carry a write enable and a byte mask.
- One transaction is outstanding at a time. The response is routed back to the requester that owns it.
- Data requests have fixed priority. A starvation counter guarantees forward progress for fetch.

Parameters:
- ADDRESS, 32, address width
- INSTRUCTION, 32, data/instruction word width
- MAX_STARVE, 4, consecutive data grants allowed while fetch is pending before fetch is forced (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDRESS  fetch address
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  INSTRUCTION  fetched instruction
- dm_req  in  1  data request
- dm_we_re  in  1  1 = write, 0 = read
- dm_mask  in  4  byte enables
- dm_addr  in  ADDRESS  data address
- dm_wdata  in  INSTRUCTION  store data
- dm_gnt  out  1  data request accepted (1-cycle pulse)
- dm_rvalid  out  1  data response/ack valid (1-cycle pulse)
- dm_rdata  out  INSTRUCTION  load data
- mem_request  out  1  request to memory
- mem_we_re  out  1  write enable to memory
- mem_mask  out  4  byte mask to memory
- mem_addr  out  ADDRESS  address to memory
- mem_wdata  out  INSTRUCTION  write data to memory
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  memory response/write-ack valid
- mem_rdata  in  INSTRUCTION  memory read data

Behaviour:
- Clocking and reset
  - All state updates on posedge clk.
  - rst=1: state←IDLE, owner←NONE, starve_cnt←0.
  - During reset, every output is 0.
- FSM states: IDLE, BUSY.
- IDLE, arbitration (combinational)
  - sel_if = if_req & (~dm_req | starve_cnt==MAX_STARVE).
  - sel_dm = dm_req & ~sel_if.
  - mem_request = sel_if | sel_dm.
- IDLE, fields driven when sel_if
  - mem_we_re=0, mem_mask=4'b1111, mem_addr=if_addr, mem_wdata=0.
- IDLE, fields driven when sel_dm
  - mem_we_re=dm_we_re, mem_mask=dm_mask, mem_addr=dm_addr, mem_wdata=dm_wdata.
- When nothing is selected, all mem_* outputs are 0.
- IDLE, handshake
  - A request is accepted when mem_request & mem_ready.
  - On acceptance: the matching gnt pulses in the same cycle, owner is latched, and state→BUSY.
  - If mem_ready=0, nothing changes and arbitration repeats next cycle. The selection may change if inputs change.
- Requester obligation: hold req and all fields stable until gnt. The arbiter does not check this.
- starve_cnt, updated on acceptance only
  - dm granted while if_req=1: starve_cnt←min(starve_cnt+1, MAX_STARVE).
  - if granted: starve_cnt←0.
  - dm granted while if_req=0: starve_cnt←0.
- BUSY
  - mem_request=0 and all mem_* fields are 0. New requests are not accepted and no gnt is issued.
- BUSY, response on mem_rvalid=1
  - Route to owner: {if|dm}_rvalid=1 and {if|dm}_rdata=mem_rdata, combinationally in the same cycle. The non-owner rvalid stays 0.
  - Then state→IDLE and owner←NONE.
- Writes complete the same way: memory returns mem_rvalid as the ack, dm_rvalid pulses, and dm_rdata is don't-care.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Latency
  - Request to gnt: 0 cycles when mem_ready=1.
  - The earliest response arrives the cycle after gnt.
  - The next acceptance is possible the cycle after the response. Minimum 2 cycles per transaction.
- Boundaries
  - mem_rvalid in IDLE is ignored (stray or late response). It produces no rvalid.
  - Reset mid-BUSY abandons the transaction. No rvalid is delivered for it, even if mem_rvalid arrives later.
  - if_req and dm_req arriving in the same cycle: dm wins unless starve_cnt==MAX_STARVE.
  - mem_rvalid in the same cycle as new requests: the response is handled and no grant is issued that cycle.

Test Plan:
- Reset mid-BUSY: dm read granted, rst=1 for 1 cycle, then mem_rvalid=1 → dm_rvalid stays 0; state IDLE; starve_cnt=0; all outputs 0.
- Fetch-only: if_req=1, if_addr=0x0000_0010, mem_ready=1, response mem_rdata=0x0000_0093 two cycles later → if_gnt pulses in cycle 0 with mem_mask=4'b1111 and mem_we_re=0; if_rvalid=1 and if_rdata=0x0000_0093 in the response cycle; dm_rvalid=0 throughout.
- Simultaneous requests: if_req=dm_req=1, dm_we_re=1, dm_mask=4'b0011, dm_addr=0x100, dm_wdata=0xDEAD_BEEF → dm_gnt first with mem fields equal to the dm inputs; after the ack, if_gnt is issued on the next IDLE cycle.
- Starvation: dm_req and if_req held at 1, with mem_ready and a 1-cycle memory response → exactly MAX_STARVE=4 dm grants, then the 5th grant goes to if; starve_cnt returns to 0.
- Backpressure: dm_req=1, mem_ready=0 for 3 cycles → mem_request=1 with stable fields and no dm_gnt; when mem_ready=1, dm_gnt pulses once.
- Stray response: mem_rvalid=1 in IDLE with mem_rdata=0x1234 → if_rvalid=dm_rvalid=0 and the state is unchanged.
